// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   state_t   : LSU control states
//   F3_*      : RV32I load/store size/sign codes
//   req_error : flags illegal funct3 or misaligned address for a request
package lsu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_DATA = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only know B/H/W; loads add the unsigned B/H variants.
    function automatic logic req_error(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU (little-endian lanes).
//   funct3     : size/sign code of the held request
//   lane       : byte address bits [1:0]
//   rd_word    : word read from data memory
//   wdata      : right-aligned store data
//   load_data  : extracted and sign/zero-extended load result
//   store_word : rd_word with the addressed lane(s) replaced (wdata for SW)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] rd_word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Load extraction and extension
    always_comb begin
        byte_v    = rd_word[{lane, 3'b000} +: 8];
        half_v    = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_BU:   load_data = {24'h0, byte_v};
            F3_HU:   load_data = {16'h0, half_v};
            default: load_data = rd_word;
        endcase
    end

    // Read-modify-write lane merge
    always_comb begin
        store_word = rd_word;
        case (funct3[1:0])
            2'b00:   store_word[{lane, 3'b000} +: 8]  = wdata[7:0];
            2'b01:   store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding request to a synchronous-read word memory.
// Sub-word stores are read-modify-write. Errors complete without memory access.
//   clk, rst_n              : clock, async active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata: request payload
//   rsp_valid/rsp_rdata/err : one-cycle completion pulse with result
//   mem_addr/mem_wr_dat/en  : word-indexed memory interface
//   mem_rd_dat              : memory read word, one cycle after mem_addr
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_dat,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rd_dat
);

    state_t            state;
    state_t            state_n;
    logic              h_we;
    logic [2:0]        h_funct3;
    logic [1:0]        h_lane;
    logic [DATA_W-1:0] h_wdata;
    logic              h_err;

    logic              accept_c;
    logic              acc_err_c;
    logic              err_n_c;
    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] store_word_c;

    assign accept_c  = req_valid && (state == S_IDLE);
    assign acc_err_c = req_error(req_we, req_funct3, req_addr[1:0]);
    assign err_n_c   = accept_c ? acc_err_c : h_err;

    lsu_align u_align (
        .funct3     (h_funct3),
        .lane       (h_lane),
        .rd_word    (mem_rd_dat),
        .wdata      (h_wdata),
        .load_data  (load_data_c),
        .store_word (store_word_c)
    );

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (acc_err_c)                state_n = S_RESP;
                    else if (!req_we)             state_n = S_RD;
                    else if (req_funct3 == F3_W)  state_n = S_WR;
                    else                          state_n = S_RD;
                end
            end
            S_RD:    state_n = S_DATA;
            S_DATA:  state_n = h_we ? S_WR : S_RESP;
            S_WR:    state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, holding registers and registered outputs (decoded from next state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wr_dat <= '0;
            h_we       <= 1'b0;
            h_funct3   <= 3'b000;
            h_lane     <= 2'b00;
            h_wdata    <= '0;
            h_err      <= 1'b0;
        end else begin
            state     <= state_n;
            req_ready <= (state_n == S_IDLE);
            rsp_valid <= (state_n == S_RESP);
            rsp_err   <= (state_n == S_RESP) && err_n_c;
            mem_wr_en <= (state_n == S_WR);

            if (accept_c) begin
                h_we     <= req_we;
                h_funct3 <= req_funct3;
                h_lane   <= req_addr[1:0];
                h_wdata  <= req_wdata;
                h_err    <= acc_err_c;
                // Erroneous requests leave the memory port untouched
                if (!acc_err_c) begin
                    mem_addr <= ADDR_W'(req_addr >> 2);
                    if (req_we && (req_funct3 == F3_W)) begin
                        mem_wr_dat <= req_wdata;
                    end
                end
            end

            if (state == S_DATA && h_we) begin
                mem_wr_dat <= store_word_c;
            end

            if (state == S_DATA && !h_we) begin
                rsp_rdata <= load_data_c;
            end else if (state_n == S_RESP) begin
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected responses and writes,
// independent monitors pop and compare when the DUT presents them.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_dat;
    logic        mem_wr_en;
    logic [31:0] mem_rd_dat;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] dat;
        int          cyc;
    } wr_exp_t;

    rsp_exp_t rsp_q[$];
    wr_exp_t  wr_q[$];
    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    logic [31:0] mem [0:1023];

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wr_dat (mem_wr_dat),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_dat (mem_rd_dat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read data memory model
    always @(posedge clk) begin
        mem_rd_dat <= mem[mem_addr[9:0]];
        if (mem_wr_en) mem[mem_addr[9:0]] <= mem_wr_dat;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                n_tot++;
                $display("FAIL rsp_unexpected: got rsp_valid at cycle %0d expected none", cyc);
            end else begin
                rsp_exp_t e;
                e = rsp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Memory-write monitor
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_tot++;
                $display("FAIL wr_unexpected: got mem_wr_en at cycle %0d expected none", cyc);
            end else begin
                wr_exp_t w;
                w = wr_q.pop_front();
                check("mem_addr", mem_addr, w.addr);
                check("mem_wr_dat", mem_wr_dat, w.dat);
                check("wr_cycle", 32'(cyc), 32'(w.cyc));
            end
        end
    end

    // Issue one request; expectations are relative to cycle 0 (the accept cycle)
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic do_rsp, input logic [31:0] exp_rd, input logic exp_err,
                         input int rlat,
                         input logic do_wr, input logic [31:0] wa, input logic [31:0] wd,
                         input int wlat);
        int waited;
        rsp_exp_t r;
        wr_exp_t  w;
        waited = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            n_tot++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        if (do_rsp) begin
            r.rdata = exp_rd; r.err = exp_err; r.cyc = cyc + rlat;
            rsp_q.push_back(r);
        end
        if (do_wr) begin
            w.addr = wa; w.dat = wd; w.cyc = cyc + wlat;
            wr_q.push_back(w);
        end
        @(posedge clk);
        #1;
        // Scramble the bus after accept; the held request must not follow it
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h8899AABB;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wr_dat", mem_wr_dat, 32'h0);
        rst_n = 1'b1;

        // Loads on word 0x8899AABB
        issue(0, F3_B,  32'h101, 0, 1, 32'hFFFFFFAA, 0, 3, 0, 0, 0, 0);
        issue(0, F3_BU, 32'h101, 0, 1, 32'h000000AA, 0, 3, 0, 0, 0, 0);
        issue(0, F3_H,  32'h102, 0, 1, 32'hFFFF8899, 0, 3, 0, 0, 0, 0);
        issue(0, F3_HU, 32'h102, 0, 1, 32'h00008899, 0, 3, 0, 0, 0, 0);
        issue(0, F3_W,  32'h100, 0, 1, 32'h8899AABB, 0, 3, 0, 0, 0, 0);
        issue(0, F3_B,  32'h100, 0, 1, 32'hFFFFFFBB, 0, 3, 0, 0, 0, 0);
        issue(0, F3_HU, 32'h100, 0, 1, 32'h0000AABB, 0, 3, 0, 0, 0, 0);

        // Stores
        issue(1, F3_B, 32'h102, 32'hFFFFFF55, 1, 32'h0, 0, 4, 1, 32'h40, 32'h8855AABB, 3);
        issue(0, F3_W, 32'h100, 0, 1, 32'h8855AABB, 0, 3, 0, 0, 0, 0);
        issue(1, F3_W, 32'h200, 32'hDEADBEEF, 1, 32'h0, 0, 2, 1, 32'h80, 32'hDEADBEEF, 1);
        issue(1, F3_H, 32'h202, 32'hABCD1234, 1, 32'h0, 0, 4, 1, 32'h80, 32'h1234BEEF, 3);
        issue(0, F3_W, 32'h200, 0, 1, 32'h1234BEEF, 0, 3, 0, 0, 0, 0);
        issue(0, F3_B, 32'h203, 0, 1, 32'h00000012, 0, 3, 0, 0, 0, 0);

        // Errors: misaligned and illegal funct3
        issue(0, F3_W,   32'h102, 0, 1, 32'h0, 1, 1, 0, 0, 0, 0);
        issue(1, F3_H,   32'h101, 32'h1111, 1, 32'h0, 1, 1, 0, 0, 0, 0);
        issue(0, 3'b011, 32'h100, 0, 1, 32'h0, 1, 1, 0, 0, 0, 0);
        issue(1, 3'b101, 32'h100, 32'h22, 1, 32'h0, 1, 1, 0, 0, 0, 0);
        issue(0, 3'b110, 32'h100, 0, 1, 32'h0, 1, 1, 0, 0, 0, 0);

        // Reset during WR of an SB: write seen in cycle 3, then aborted
        issue(1, F3_B, 32'h100, 32'h77, 0, 0, 0, 0, 1, 32'h40, 32'h8855AA77, 3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        issue(0, F3_W, 32'h100, 0, 1, 32'h8855AABB, 0, 3, 0, 0, 0, 0);

        // Drain with a bound, then everything expected must have appeared
        for (int i = 0; i < 50 && (rsp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of core requests.
REQ-002 Parameter DATA_W, default 32: data word width; only 32 is supported.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port req_valid  input  1: core presents a memory request.
REQ-006 Port req_ready  output  1: LSU accepts a request this cycle; high only in IDLE.
REQ-007 Port req_we  input  1: 1 = store, 0 = load.
REQ-008 Port req_funct3  input  3: RV32I size/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-009 Port req_addr  input  ADDR_W: byte address.
REQ-010 Port req_wdata  input  DATA_W: store data, right-aligned.
REQ-011 Port rsp_valid  output  1: one-cycle pulse marking request completion.
REQ-012 Port rsp_rdata  output  DATA_W: load result, extended per funct3; 0 for stores and errors.
REQ-013 Port rsp_err  output  1: valid with rsp_valid; misaligned address or illegal funct3.
REQ-014 Port mem_addr  output  ADDR_W: word index to data memory, equal to req_addr >> 2.
REQ-015 Port mem_wr_dat  output  DATA_W: full word written to data memory.
REQ-016 Port mem_wr_en  output  1: data memory write strobe, one cycle per store.
REQ-017 Port mem_rd_dat  input  DATA_W: data memory read word, valid one cycle after mem_addr is presented (synchronous read).

Function
REQ-018 The request SHALL be captured into holding registers on the edge where req_valid and req_ready are both 1; later req_* changes SHALL be ignored.
REQ-019 The FSM SHALL use states IDLE, RD, DATA, WR, RESP; only IDLE asserts req_ready.
REQ-020 Transitions from IDLE on accept: error to RESP; load to RD; SW to WR; SB/SH to RD.
REQ-021 Transitions: RD to DATA; DATA to RESP for a load or WR for a store; WR to RESP; RESP to IDLE.
REQ-022 Latency from accept edge (cycle 0): load rsp_valid in cycle 3; SW in cycle 2; SB/SH in cycle 4; error in cycle 1.
REQ-023 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0; such requests SHALL cause no memory access.
REQ-024 Illegal funct3: loads 011/110/111, stores 011..111; treated as errors.
REQ-025 Byte lanes SHALL be little-endian: lane = addr[1:0]; halfword lane = addr[1].
REQ-026 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL return the word unchanged.
REQ-027 For SB/SH, the read word captured in DATA SHALL be registered with only the addressed lane(s) replaced; WR drives it with mem_wr_en=1.
REQ-028 For SW, WR SHALL drive req_wdata unchanged.
REQ-029 mem_wr_en SHALL be 1 only in WR; mem_addr SHALL hold the latched word index from RD through WR.
REQ-030 rsp_valid and rsp_err SHALL be 1 only in RESP, for exactly one cycle; rsp_rdata SHALL be registered.

Reset
REQ-031 While rst_n=0: state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wr_en=0, mem_addr=0, mem_wr_dat=0, holding registers=0, and req_ready=1.
REQ-032 Reset asserted mid-operation SHALL abort the operation immediately with no response; a reset during WR SHALL drop mem_wr_en before the next edge.

Structure
REQ-033 Package lsu_pkg SHALL hold the state enum and the funct3 constants.
REQ-034 A combinational sub-module lsu_align SHALL perform load extraction/extension and store lane merge; the FSM stays in lsu.

Verification
REQ-035 Memory word 0x100>>2 = 0x8899AABB; LB at 0x101 -> rsp_rdata 0xFFFFFFAA in cycle 3; LBU at 0x101 -> 0x000000AA.
REQ-036 LH at 0x102 on the same word -> 0xFFFF8899; LHU -> 0x00008899; LW at 0x100 -> 0x8899AABB.
REQ-037 SB 0x55 at 0x102 on word 0x8899AABB -> single mem_wr_en in cycle 3 with 0x8855AABB; rsp_valid in cycle 4.
REQ-038 SW 0xDEADBEEF at 0x200 -> mem_wr_en in cycle 1 with mem_addr 0x80; rsp_valid in cycle 2, rsp_err=0.
REQ-039 LW at 0x102, SH at 0x101, LB with funct3 011 -> rsp_err=1 in cycle 1; mem_wr_en never asserted.
REQ-040 rst_n dropped during WR of an SB -> mem_wr_en=0 immediately, no rsp_valid; req_ready=1 after release.
